// File: rtl/pipe_pulse_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pulse_scheduler
//  Description : Round-robin launcher for a shared pulse pipeline with launch
//                spacing, in-flight cap and in-order ID return.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_pulse_scheduler #(
    parameter int NREQ         = 4,
    parameter int IDW          = 2,
    parameter int MIN_GAP      = 2,
    parameter int MAX_INFLIGHT = 4,
    parameter int CNTW         = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic            launch,
    input  logic            pipe_done,
    output logic            done,
    output logic [IDW-1:0]  done_id,
    output logic [CNTW-1:0] inflight,
    output logic            busy,
    output logic            err_unexp
);

    localparam int c_GAP_W  = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam int c_FIFO_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

    logic [IDW-1:0]      r_ptr;
    logic [c_GAP_W-1:0]  r_gap;
    logic [CNTW-1:0]     r_inflight;
    logic [IDW-1:0]      r_fifo [MAX_INFLIGHT];
    logic [c_FIFO_W-1:0] r_wr;
    logic [c_FIFO_W-1:0] r_rd;
    logic [NREQ-1:0]     r_gnt;
    logic                r_launch;
    logic                r_done;
    logic [IDW-1:0]      r_done_id;
    logic                r_busy;
    logic                r_err;

    logic                w_found;
    logic [IDW-1:0]      w_win;
    logic                w_grant;
    logic                w_pop;
    logic [CNTW-1:0]     w_inflight_nxt;

    // Scan from the pointer upward with wrap; first set request wins.
    always_comb begin
        int v_idx;
        w_found = 1'b0;
        w_win   = '0;
        v_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            v_idx = int'(r_ptr) + k;
            if (v_idx >= NREQ) begin
                v_idx = v_idx - NREQ;
            end
            if (!w_found && req[v_idx]) begin
                w_found = 1'b1;
                w_win   = IDW'(v_idx);
            end
        end
    end

    // Full check sees the registered count, so a same-cycle pop cannot unblock.
    assign w_grant = en && (r_gap == '0) && (r_inflight < CNTW'(MAX_INFLIGHT)) && w_found;
    assign w_pop   = pipe_done && (r_inflight != '0);

    always_comb begin
        w_inflight_nxt = r_inflight;
        case ({w_grant, w_pop})
            2'b10:   w_inflight_nxt = r_inflight + CNTW'(1);
            2'b01:   w_inflight_nxt = r_inflight - CNTW'(1);
            default: w_inflight_nxt = r_inflight;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_gap      <= '0;
            r_inflight <= '0;
            r_wr       <= '0;
            r_rd       <= '0;
            r_gnt      <= '0;
            r_launch   <= 1'b0;
            r_done     <= 1'b0;
            r_done_id  <= '0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_launch   <= w_grant;
            r_gnt      <= w_grant ? (NREQ'(1) << w_win) : '0;
            r_done     <= w_pop;
            r_done_id  <= w_pop ? r_fifo[r_rd] : '0;
            r_inflight <= w_inflight_nxt;
            r_busy     <= (w_inflight_nxt != '0);
            if (pipe_done && (r_inflight == '0)) begin
                r_err <= 1'b1;
            end
            if (w_grant) begin
                r_ptr <= (w_win == IDW'(NREQ-1)) ? '0 : w_win + IDW'(1);
                r_gap <= c_GAP_W'(MIN_GAP-1);
                r_wr  <= (r_wr == c_FIFO_W'(MAX_INFLIGHT-1)) ? '0 : r_wr + c_FIFO_W'(1);
            end else if (r_gap != '0) begin
                r_gap <= r_gap - c_GAP_W'(1);
            end
            if (w_pop) begin
                r_rd <= (r_rd == c_FIFO_W'(MAX_INFLIGHT-1)) ? '0 : r_rd + c_FIFO_W'(1);
            end
        end
    end

    // ID storage needs no reset: emptiness is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_fifo[r_wr] <= w_win;
        end
    end

    assign gnt       = r_gnt;
    assign launch    = r_launch;
    assign done      = r_done;
    assign done_id   = r_done_id;
    assign inflight  = r_inflight;
    assign busy      = r_busy;
    assign err_unexp = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pipe_pulse_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_pulse_scheduler
//  Description : Directed vector bench for pipe_pulse_scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_pulse_scheduler;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [3:0] req;
        logic       pd;
        logic [3:0] gnt;
        logic       launch;
        logic       done;
        logic [1:0] did;
        logic [2:0] infl;
        logic       err;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       launch;
    logic       pipe_done;
    logic       done;
    logic [1:0] done_id;
    logic [2:0] inflight;
    logic       busy;
    logic       err_unexp;

    int   n_vec;
    int   n_err;
    vec_t vq[$];

    pipe_pulse_scheduler #(
        .NREQ(4), .IDW(2), .MIN_GAP(2), .MAX_INFLIGHT(4), .CNTW(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .gnt(gnt),
        .launch(launch), .pipe_done(pipe_done), .done(done),
        .done_id(done_id), .inflight(inflight), .busy(busy),
        .err_unexp(err_unexp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic rn, input logic e, input logic [3:0] rq, input logic pd,
                       input logic [3:0] g, input logic l, input logic d, input logic [1:0] id,
                       input logic [2:0] inf, input logic er);
        vec_t v;
        v.rst_n = rn; v.en = e; v.req = rq; v.pd = pd;
        v.gnt = g; v.launch = l; v.done = d; v.did = id; v.infl = inf; v.err = er;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [7:0] got, input logic [7:0] want);
        if (got !== want) begin
            n_err++;
            $display("FAIL %s vec %0d: got %0h want %0h", nm, idx, got, want);
        end
    endtask

    task automatic check_outs(input int idx, input vec_t v);
        n_vec++;
        chk("gnt",       idx, 8'(gnt),       8'(v.gnt));
        chk("launch",    idx, 8'(launch),    8'(v.launch));
        chk("done",      idx, 8'(done),      8'(v.done));
        if (v.done) chk("done_id", idx, 8'(done_id), 8'(v.did));
        chk("inflight",  idx, 8'(inflight),  8'(v.infl));
        chk("busy",      idx, 8'(busy),      8'(v.infl != 3'd0));
        chk("err_unexp", idx, 8'(err_unexp), 8'(v.err));
    endtask

    task automatic apply(input int idx, input vec_t v);
        rst_n = v.rst_n; en = v.en; req = v.req; pipe_done = v.pd;
        @(posedge clk);
        #1;
        check_outs(idx, v);
    endtask

    initial begin
        vec_t z;
        n_vec = 0; n_err = 0;
        rst_n = 1'b0; en = 1'b0; req = 4'h0; pipe_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // single requester, return five cycles after launch
        add(0,0,4'h0,0, 4'h0,0,0,0,0,0);
        add(1,1,4'h1,0, 4'h1,1,0,0,1,0);
        add(1,1,4'h1,0, 4'h0,0,0,0,1,0);
        for (int i = 0; i < 4; i++) add(1,1,4'h0,0, 4'h0,0,0,0,1,0);
        add(1,1,4'h0,1, 4'h0,0,1,0,0,0);
        add(1,1,4'h0,0, 4'h0,0,0,0,0,0);
        // all requesting: rotation every MIN_GAP cycles, wrap 3 -> 0
        add(0,0,4'h0,0, 4'h0,0,0,0,0,0);
        add(1,1,4'hF,0, 4'h1,1,0,0,1,0);
        add(1,1,4'hF,0, 4'h0,0,0,0,1,0);
        add(1,1,4'hF,0, 4'h2,1,0,0,2,0);
        add(1,1,4'hF,0, 4'h0,0,0,0,2,0);
        add(1,1,4'hF,0, 4'h4,1,0,0,3,0);
        add(1,1,4'hF,1, 4'h0,0,1,0,2,0);
        add(1,1,4'hF,0, 4'h8,1,0,0,3,0);
        add(1,1,4'hF,0, 4'h0,0,0,0,3,0);
        add(1,1,4'hF,0, 4'h1,1,0,0,4,0);
        add(1,1,4'hF,1, 4'h0,0,1,1,3,0);
        add(1,1,4'h0,1, 4'h0,0,1,2,2,0);
        add(1,1,4'h0,1, 4'h0,0,1,3,1,0);
        add(1,1,4'h0,1, 4'h0,0,1,0,0,0);
        add(1,1,4'h0,0, 4'h0,0,0,0,0,0);
        // IDs 2,0,3 returned in order; launch coinciding with return
        add(1,1,4'h4,0, 4'h4,1,0,0,1,0);
        add(1,1,4'h4,0, 4'h0,0,0,0,1,0);
        add(1,1,4'h1,0, 4'h1,1,0,0,2,0);
        add(1,1,4'h1,0, 4'h0,0,0,0,2,0);
        add(1,1,4'h8,0, 4'h8,1,0,0,3,0);
        add(1,1,4'h8,1, 4'h0,0,1,2,2,0);
        add(1,1,4'h0,1, 4'h0,0,1,0,1,0);
        add(1,1,4'h2,1, 4'h2,1,1,3,1,0);
        add(1,1,4'h2,0, 4'h0,0,0,0,1,0);
        add(1,1,4'h0,1, 4'h0,0,1,1,0,0);
        // in-flight cap: fifth grant waits until the count has dropped
        add(0,0,4'h0,0, 4'h0,0,0,0,0,0);
        add(1,1,4'hF,0, 4'h1,1,0,0,1,0);
        add(1,1,4'hF,0, 4'h0,0,0,0,1,0);
        add(1,1,4'hF,0, 4'h2,1,0,0,2,0);
        add(1,1,4'hF,0, 4'h0,0,0,0,2,0);
        add(1,1,4'hF,0, 4'h4,1,0,0,3,0);
        add(1,1,4'hF,0, 4'h0,0,0,0,3,0);
        add(1,1,4'hF,0, 4'h8,1,0,0,4,0);
        add(1,1,4'hF,0, 4'h0,0,0,0,4,0);
        add(1,1,4'hF,0, 4'h0,0,0,0,4,0);
        add(1,1,4'hF,0, 4'h0,0,0,0,4,0);
        add(1,1,4'hF,1, 4'h0,0,1,0,3,0);
        add(1,1,4'hF,0, 4'h1,1,0,0,4,0);
        add(1,1,4'h0,1, 4'h0,0,1,1,3,0);
        add(1,1,4'h0,1, 4'h0,0,1,2,2,0);
        add(1,1,4'h0,1, 4'h0,0,1,3,1,0);
        add(1,1,4'h0,1, 4'h0,0,1,0,0,0);
        // unexpected return: sticky error, cleared only by reset
        add(1,1,4'h0,1, 4'h0,0,0,0,0,1);
        add(1,1,4'h1,0, 4'h1,1,0,0,1,1);
        add(1,1,4'h1,0, 4'h0,0,0,0,1,1);
        add(1,1,4'h0,1, 4'h0,0,1,0,0,1);
        add(1,0,4'hF,0, 4'h0,0,0,0,0,1);
        add(0,0,4'h0,0, 4'h0,0,0,0,0,0);

        for (int i = 0; i < vq.size(); i++) apply(i, vq[i]);

        // async reset mid-flight (inflight=2, gap pending, ptr=2)
        vq.delete();
        add(1,1,4'hF,0, 4'h1,1,0,0,1,0);
        add(1,1,4'hF,0, 4'h0,0,0,0,1,0);
        add(1,1,4'hF,0, 4'h2,1,0,0,2,0);
        for (int i = 0; i < vq.size(); i++) apply(100 + i, vq[i]);
        rst_n = 1'b0;
        #1;
        z.gnt = 4'h0; z.launch = 1'b0; z.done = 1'b0; z.did = 2'd0; z.infl = 3'd0; z.err = 1'b0;
        check_outs(200, z);
        @(posedge clk);
        #1;
        vq.delete();
        add(1,1,4'h6,0, 4'h2,1,0,0,1,0);
        add(1,1,4'h6,0, 4'h0,0,0,0,1,0);
        add(1,1,4'h0,1, 4'h0,0,1,1,0,0);
        add(1,1,4'h0,1, 4'h0,0,0,0,0,1);
        for (int i = 0; i < vq.size(); i++) apply(201 + i, vq[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
